// File: rtl/tlul_arbiter_2to1.sv
// tlul_arbiter_2to1
//   Two-host, one-slave TileLink-UL arbiter. One transaction is in flight at a
//   time: arbitrate (IDLE), forward A (ADDR), forward D (RESP), then
//   re-arbitrate. On a tie, priority pointer p decides. After every completed
//   transaction, p moves to the master that was not just served. D responses
//   are steered by the registered grant index, never by decoding d_source.
//
// Ports
//   i_clk, i_reset          clock and synchronous active-high reset
//   i_m_a_* / o_m_a_ready   per-master A channel, packed with master n at slice n
//   o_m_d_valid/i_m_d_ready per-master D handshake
//   o_m_d_*                 D payload broadcast to both masters, qualified by o_m_d_valid
//   o_s_a_* / i_s_a_ready   slave A channel
//   i_s_d_* / o_s_d_ready   slave D channel
//   o_grant, o_busy         one-hot grant while busy, and the busy flag

// Per-master handshake gating. Only the granted master sees any handshake.
module tlul_arb_port (
  input  logic sel,
  input  logic in_addr,
  input  logic in_resp,
  input  logic s_a_ready,
  input  logic s_d_valid,
  input  logic m_d_ready,
  output logic a_ready,
  output logic d_valid,
  output logic d_take
);
  assign a_ready = sel & in_addr & s_a_ready;
  assign d_valid = sel & in_resp & s_d_valid;
  // This master's contribution to the slave d_ready.
  assign d_take  = sel & in_resp & m_d_ready;
endmodule

module tlul_arbiter_2to1 #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_m_a_valid,
  output logic [1:0]          o_m_a_ready,
  input  logic [2*3-1:0]      i_m_a_opcode,
  input  logic [2*2-1:0]      i_m_a_size,
  input  logic [2*SW-1:0]     i_m_a_source,
  input  logic [2*AW-1:0]     i_m_a_address,
  input  logic [2*(DW/8)-1:0] i_m_a_mask,
  input  logic [2*DW-1:0]     i_m_a_data,
  output logic [1:0]          o_m_d_valid,
  input  logic [1:0]          i_m_d_ready,
  output logic [2:0]          o_m_d_opcode,
  output logic [1:0]          o_m_d_size,
  output logic [SW-1:0]       o_m_d_source,
  output logic [DW-1:0]       o_m_d_data,
  output logic                o_m_d_error,
  output logic                o_s_a_valid,
  input  logic                i_s_a_ready,
  output logic [2:0]          o_s_a_opcode,
  output logic [1:0]          o_s_a_size,
  output logic [SW-1:0]       o_s_a_source,
  output logic [AW-1:0]       o_s_a_address,
  output logic [DW/8-1:0]     o_s_a_mask,
  output logic [DW-1:0]       o_s_a_data,
  input  logic                i_s_d_valid,
  output logic                o_s_d_ready,
  input  logic [2:0]          i_s_d_opcode,
  input  logic [1:0]          i_s_d_size,
  input  logic [SW-1:0]       i_s_d_source,
  input  logic [DW-1:0]       i_s_d_data,
  input  logic                i_s_d_error,
  output logic [1:0]          o_grant,
  output logic                o_busy
);
  localparam int NM = 2;
  localparam int MW = DW / 8;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [1:0]    size;
    logic [SW-1:0] source;
    logic [AW-1:0] address;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } a_req_t;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t state, state_nx;
  logic   g, g_nx;   // granted master index
  logic   p, p_nx;   // master that wins a tie

  a_req_t [NM-1:0] a_req;
  logic   [NM-1:0] sel;
  logic   [NM-1:0] d_take;
  logic            in_addr, in_resp, d_done;

  assign in_addr = (state == ADDR);
  assign in_resp = (state == RESP);

  generate
    for (genvar n = 0; n < NM; n++) begin : g_port
      assign a_req[n] = '{
        opcode:  i_m_a_opcode[n*3 +: 3],
        size:    i_m_a_size[n*2 +: 2],
        source:  i_m_a_source[n*SW +: SW],
        address: i_m_a_address[n*AW +: AW],
        mask:    i_m_a_mask[n*MW +: MW],
        data:    i_m_a_data[n*DW +: DW]
      };
      assign sel[n] = (g == 1'(n));

      tlul_arb_port u_port (
        .sel       (sel[n]),
        .in_addr   (in_addr),
        .in_resp   (in_resp),
        .s_a_ready (i_s_a_ready),
        .s_d_valid (i_s_d_valid),
        .m_d_ready (i_m_d_ready[n]),
        .a_ready   (o_m_a_ready[n]),
        .d_valid   (o_m_d_valid[n]),
        .d_take    (d_take[n])
      );
    end
  endgenerate

  assign o_s_d_ready = |d_take;
  assign d_done      = i_s_d_valid & o_s_d_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      g     <= 1'b0;
      p     <= 1'b0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      p     <= p_nx;
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    p_nx     = p;
    case (state)
      IDLE: begin
        if (|i_m_a_valid) begin
          // A lone requester wins outright. On a tie, p decides.
          g_nx     = (&i_m_a_valid) ? p : i_m_a_valid[1];
          state_nx = ADDR;
        end
      end
      ADDR: begin
        // The grant is held until the slave accepts. It is never revoked.
        if (i_s_a_ready) state_nx = RESP;
      end
      RESP: begin
        if (d_done) begin
          state_nx = IDLE;
          p_nx     = ~g;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The A fields come from the granted master, which holds them stable while valid.
  assign o_s_a_valid   = in_addr;
  assign o_s_a_opcode  = a_req[g].opcode;
  assign o_s_a_size    = a_req[g].size;
  assign o_s_a_source  = a_req[g].source;
  assign o_s_a_address = a_req[g].address;
  assign o_s_a_mask    = a_req[g].mask;
  assign o_s_a_data    = a_req[g].data;

  // The D payload is broadcast unchanged. Routing is done by o_m_d_valid alone.
  assign o_m_d_opcode = i_s_d_opcode;
  assign o_m_d_size   = i_s_d_size;
  assign o_m_d_source = i_s_d_source;
  assign o_m_d_data   = i_s_d_data;
  assign o_m_d_error  = i_s_d_error;

  assign o_busy  = (state != IDLE);
  assign o_grant = {o_busy & g, o_busy & ~g};
endmodule

// File: tb/tb_tlul_arbiter_2to1.sv
module tb_tlul_arbiter_2to1;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MW = DW / 8;

  typedef struct packed {
    logic [2:0]    op;
    logic [1:0]    size;
    logic [SW-1:0] src;
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } areq_t;

  typedef struct packed {
    logic  m;
    areq_t r;
  } aexp_t;

  typedef struct packed {
    logic          m;
    logic [2:0]    op;
    logic [1:0]    size;
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    logic          err;
  } dexp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]      m_a_valid, m_a_ready, m_d_valid, m_d_ready, grant;
  logic [5:0]      m_a_opcode;
  logic [3:0]      m_a_size;
  logic [2*SW-1:0] m_a_source;
  logic [2*AW-1:0] m_a_address;
  logic [2*MW-1:0] m_a_mask;
  logic [2*DW-1:0] m_a_data;
  logic [2:0]      m_d_opcode, s_a_opcode, s_d_opcode;
  logic [1:0]      m_d_size, s_a_size, s_d_size;
  logic [SW-1:0]   m_d_source, s_a_source, s_d_source;
  logic [DW-1:0]   m_d_data, s_a_data, s_d_data;
  logic [AW-1:0]   s_a_address;
  logic [MW-1:0]   s_a_mask;
  logic            m_d_error, s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_error, busy;

  tlul_arbiter_2to1 #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m_a_valid(m_a_valid), .o_m_a_ready(m_a_ready),
    .i_m_a_opcode(m_a_opcode), .i_m_a_size(m_a_size), .i_m_a_source(m_a_source),
    .i_m_a_address(m_a_address), .i_m_a_mask(m_a_mask), .i_m_a_data(m_a_data),
    .o_m_d_valid(m_d_valid), .i_m_d_ready(m_d_ready),
    .o_m_d_opcode(m_d_opcode), .o_m_d_size(m_d_size), .o_m_d_source(m_d_source),
    .o_m_d_data(m_d_data), .o_m_d_error(m_d_error),
    .o_s_a_valid(s_a_valid), .i_s_a_ready(s_a_ready),
    .o_s_a_opcode(s_a_opcode), .o_s_a_size(s_a_size), .o_s_a_source(s_a_source),
    .o_s_a_address(s_a_address), .o_s_a_mask(s_a_mask), .o_s_a_data(s_a_data),
    .i_s_d_valid(s_d_valid), .o_s_d_ready(s_d_ready),
    .i_s_d_opcode(s_d_opcode), .i_s_d_size(s_d_size), .i_s_d_source(s_d_source),
    .i_s_d_data(s_d_data), .i_s_d_error(s_d_error),
    .o_grant(grant), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model and stimulus state. Only the main initial block writes these.
  // mph: 0 = no transaction, 1 = granted and waiting for the slave to accept A,
  // 2 = waiting for the D handshake.
  int    mph = 0, mg = 0, prio = 0;
  int    mst [2];              // per master: 0 idle, 1 presenting A, 2 waiting for D
  areq_t req [2];
  int    s_st = 0, s_cnt = 0;  // slave: 0 idle, 1 response delay, 2 presenting D
  dexp_t s_resp;
  int    issue_pct = 0, ar_pct = 100, max_delay = 0;
  int    dr_pct [2];
  bit    get_only = 0, hold_stale = 0, force_d = 0, fd_err = 0, mon_en = 0;
  logic [DW-1:0] fd_data = '0;
  aexp_t exp_a [$];
  dexp_t exp_d [$];

  // Monitor-owned state.
  int         a_rd = 0, d_rd = 0, busy_cyc = 0;
  logic [1:0] glog [$];
  logic [1:0] oh, hs;
  aexp_t      ea;
  dexp_t      ed;

  function automatic areq_t rand_req(input bit get);
    areq_t r;
    int k;
    k      = $urandom_range(2, 0);
    r.op   = (get || k == 0) ? 3'd4 : (k == 1 ? 3'd0 : 3'd1);
    r.size = 2'($urandom_range(3, 0));
    r.src  = SW'($urandom);
    r.addr = $urandom;
    r.mask = MW'($urandom);
    r.data = $urandom;
    return r;
  endfunction

  function automatic dexp_t make_resp(input int m, input areq_t r);
    dexp_t d;
    d.m    = m[0];
    d.op   = (r.op == 3'd4) ? 3'd1 : 3'd0;  // AccessAckData for Get, AccessAck otherwise
    d.size = r.size;
    d.src  = r.src;
    d.data = force_d ? fd_data : $urandom;
    d.err  = force_d ? fd_err : ($urandom_range(3, 0) == 0);
    return d;
  endfunction

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      m_a_valid[m]            = (mst[m] == 1);
      m_a_opcode[m*3 +: 3]    = req[m].op;
      m_a_size[m*2 +: 2]      = req[m].size;
      m_a_source[m*SW +: SW]  = req[m].src;
      m_a_address[m*AW +: AW] = req[m].addr;
      m_a_mask[m*MW +: MW]    = req[m].mask;
      m_a_data[m*DW +: DW]    = req[m].data;
      m_d_ready[m]            = ($urandom_range(99, 0) < dr_pct[m]);
    end
    s_a_ready  = ($urandom_range(99, 0) < ar_pct);
    s_d_valid  = (s_st == 2);
    s_d_opcode = s_resp.op;
    s_d_size   = s_resp.size;
    s_d_source = s_resp.src;
    s_d_data   = s_resp.data;
    s_d_error  = s_resp.err;
  endtask

  // One clock. The model first applies what the previous cycle's inputs imply
  // under the arbitration rules. Then it drives the new cycle's inputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      mph  = 0;
      prio = 0;
      for (int m = 0; m < 2; m++) if (mst[m] == 2) mst[m] = 0;
      if (!hold_stale) s_st = 0;
    end else begin
      case (mph)
        0: if (m_a_valid != 2'b00) begin
             mg  = (m_a_valid == 2'b11) ? prio : (m_a_valid[1] ? 1 : 0);
             mph = 1;
             exp_a.push_back('{m: mg[0], r: req[mg]});
           end
        1: if (s_a_ready) begin
             mph     = 2;
             mst[mg] = 2;
             s_resp  = make_resp(mg, req[mg]);
             exp_d.push_back(s_resp);
             s_st  = 1;
             s_cnt = $urandom_range(max_delay, 0);
           end
        default: if (s_d_valid && m_d_ready[mg]) begin
             mph     = 0;
             prio    = 1 - mg;
             mst[mg] = 0;
             s_st    = 0;
           end
      endcase
    end
    if (s_st == 1) begin
      if (s_cnt == 0) s_st = 2;
      else s_cnt--;
    end
    for (int m = 0; m < 2; m++)
      if (mst[m] == 0 && issue_pct > 0 && $urandom_range(99, 0) < issue_pct) begin
        req[m] = rand_req(get_only);
        mst[m] = 1;
      end
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    issue_pct = 0;
    ar_pct    = 100;
    dr_pct[0] = 100;
    dr_pct[1] = 100;
    while ((mph != 0 || mst[0] != 0 || mst[1] != 0 || s_st != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_ph(input int ph);
    int n;
    n = 0;
    while (mph != ph && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("wait_phase_timeout", 64'(mph), 64'(ph));
  endtask

  // Monitor: compares the DUT against the model state and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      oh = (mg == 1) ? 2'b10 : 2'b01;
      if (busy) busy_cyc++;
      chk("busy", busy, mph != 0);
      chk("grant", grant, (mph != 0) ? oh : 2'b00);
      chk("s_a_valid", s_a_valid, mph == 1);
      chk("m_a_ready", m_a_ready, (mph == 1 && s_a_ready) ? oh : 2'b00);
      chk("m_d_valid", m_d_valid, (mph == 2 && s_d_valid) ? oh : 2'b00);
      chk("s_d_ready", s_d_ready, mph == 2 && m_d_ready[mg]);
      if (mph == 1) begin
        chk("s_a_opcode_hold", s_a_opcode, req[mg].op);
        chk("s_a_address_hold", s_a_address, req[mg].addr);
        chk("s_a_data_hold", s_a_data, req[mg].data);
      end
      if (s_a_valid && s_a_ready) begin
        if (a_rd < exp_a.size()) begin
          ea = exp_a[a_rd];
          a_rd++;
          glog.push_back(grant);
          chk("a_grant", grant, ea.m ? 2'b10 : 2'b01);
          chk("a_opcode", s_a_opcode, ea.r.op);
          chk("a_size", s_a_size, ea.r.size);
          chk("a_source", s_a_source, ea.r.src);
          chk("a_address", s_a_address, ea.r.addr);
          chk("a_mask", s_a_mask, ea.r.mask);
          chk("a_data", s_a_data, ea.r.data);
        end else chk("a_unexpected", 64'(a_rd), 64'(exp_a.size()));
      end
      hs = m_d_valid & m_d_ready;
      if (hs != 2'b00) begin
        if (d_rd < exp_d.size()) begin
          ed = exp_d[d_rd];
          d_rd++;
          chk("d_route", hs, ed.m ? 2'b10 : 2'b01);
          chk("d_opcode", m_d_opcode, ed.op);
          chk("d_size", m_d_size, ed.size);
          chk("d_source", m_d_source, ed.src);
          chk("d_data", m_d_data, ed.data);
          chk("d_error", m_d_error, ed.err);
        end else chk("d_unexpected", 64'(d_rd), 64'(exp_d.size()));
      end
      // Transactions cut off by reset are dropped from the scoreboard.
      if (rst) begin
        a_rd = exp_a.size();
        d_rd = exp_d.size();
      end
    end
  end

  int g0, b0, n;

  initial begin
    dr_pct[0] = 100;
    dr_pct[1] = 100;
    mst[0] = 0;
    mst[1] = 0;
    s_resp = '0;

    // Reset held for 3 cycles while both masters request. m0 is granted first afterwards.
    req[0] = rand_req(1'b1);
    req[1] = rand_req(1'b1);
    mst[0] = 1;
    mst[1] = 1;
    rst    = 1'b1;
    drive();
    step();
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    g0  = glog.size();
    drain();
    chk("rst_grant_count", 64'(glog.size() - g0), 64'(2));
    if (glog.size() >= g0 + 2) begin
      chk("rst_first_grant", glog[g0], 2'b01);
      chk("rst_second_grant", glog[g0+1], 2'b10);
    end

    // Single PutFull from m1 with a zero-wait slave: busy only in ADDR and RESP.
    max_delay = 0;
    b0 = busy_cyc;
    req[1] = '{op: 3'd0, size: 2'd2, src: 4'h9, addr: 32'h0, mask: 4'hF, data: 32'h0000_00A5};
    mst[1] = 1;
    drive();
    drain();
    chk("single_busy_cycles", 64'(busy_cyc - b0), 64'(2));

    // Both masters issue Gets back to back. Grants must alternate starting at m0.
    max_delay = 1;
    get_only  = 1;
    issue_pct = 100;
    g0 = glog.size();
    n  = 0;
    while (glog.size() < g0 + 4 && n < 200) begin
      step();
      n++;
    end
    drain();
    get_only = 0;
    chk("contention_grants", 64'(glog.size() >= g0 + 4), 64'(1));
    if (glog.size() >= g0 + 4)
      for (int k = 0; k < 4; k++) chk("contention_order", glog[g0+k], (k % 2 == 0) ? 2'b01 : 2'b10);

    // Backpressure: the slave stalls A for 5 cycles, then m0 stalls D for 3 cycles.
    // m1 requests in the meantime and must wait.
    max_delay = 0;
    ar_pct = 0;
    req[0] = rand_req(1'b1);
    mst[0] = 1;
    drive();
    wait_ph(1);
    req[1] = rand_req(1'b0);
    mst[1] = 1;
    drive();
    repeat (5) step();
    ar_pct    = 100;
    dr_pct[0] = 0;
    drive();
    wait_ph(2);
    repeat (3) step();
    drain();

    // Error and data passthrough to m1.
    force_d = 1;
    fd_data = 32'h0000_003C;
    fd_err  = 1;
    req[1] = rand_req(1'b1);
    mst[1] = 1;
    drive();
    drain();
    force_d = 0;

    // Reset while m1's D handshake is pending, with p already moved to m1.
    // The stale slave response is not forwarded, and p returns to m0.
    req[0] = rand_req(1'b0);
    mst[0] = 1;
    drive();
    drain();
    req[1] = rand_req(1'b1);
    mst[1] = 1;
    dr_pct[1] = 0;
    drive();
    wait_ph(2);
    step();
    hold_stale = 1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    dr_pct[1] = 100;
    drive();
    repeat (3) step();
    hold_stale = 0;
    s_st = 0;
    req[0] = rand_req(1'b0);
    req[1] = rand_req(1'b0);
    mst[0] = 1;
    mst[1] = 1;
    drive();
    g0 = glog.size();
    drain();
    if (glog.size() > g0) chk("post_reset_grant", glog[g0], 2'b01);
    else chk("post_reset_grant_missing", 64'(glog.size()), 64'(g0 + 1));

    // Randomized traffic under random backpressure.
    issue_pct = 35;
    ar_pct    = 70;
    dr_pct[0] = 70;
    dr_pct[1] = 70;
    max_delay = 3;
    repeat (800) step();
    drain();
    repeat (2) step();

    chk("a_all_seen", 64'(a_rd), 64'(exp_a.size()));
    chk("d_all_seen", 64'(d_rd), 64'(exp_d.size()));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlul_arbiter_2to1.md
Name: tlul_arbiter_2to1

Overview:
- Two-master, one-slave TileLink-UL arbiter. It shares one TL-UL slave (e.g. tlulSlaveLeds) between two hosts, such as the CPU and the debug/test master.
- Round-robin grant with one outstanding transaction at a time: A-channel request, then wait for the D response, then re-arbitrate.
- D responses are routed back by the registered grant, not by a_source decode.

Parameters:
- AW, 32, address width.
- DW, 32, data width; mask width is DW/8.
- SW, 4, a_source/d_source width.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_m_a_valid  in  2  per-master A valid; bit n = master n.
- o_m_a_ready  out  2  per-master A ready.
- i_m_a_opcode  in  2*3  per-master packed opcode (Get=4, PutFull=0, PutPartial=1).
- i_m_a_size  in  2*2  per-master packed size.
- i_m_a_source  in  2*SW  per-master packed source.
- i_m_a_address  in  2*AW  per-master packed address.
- i_m_a_mask  in  2*(DW/8)  per-master packed mask.
- i_m_a_data  in  2*DW  per-master packed data.
- o_m_d_valid  out  2  per-master D valid.
- i_m_d_ready  in  2  per-master D ready.
- o_m_d_opcode  out  3  D opcode, broadcast; qualified by o_m_d_valid.
- o_m_d_size  out  2  broadcast D size.
- o_m_d_source  out  SW  broadcast D source.
- o_m_d_data  out  DW  broadcast D data.
- o_m_d_error  out  1  broadcast D error.
- o_s_a_valid  out  1  slave A valid.
- i_s_a_ready  in  1  slave A ready.
- o_s_a_opcode, o_s_a_size, o_s_a_source, o_s_a_address, o_s_a_mask, o_s_a_data  out  3/2/SW/AW/DW/8/DW  slave A fields.
- i_s_d_valid  in  1  slave D valid.
- o_s_d_ready  out  1  slave D ready.
- i_s_d_opcode, i_s_d_size, i_s_d_source, i_s_d_data, i_s_d_error  in  3/2/SW/DW/1  slave D fields.
- o_grant  out  2  one-hot current grant; 0 when idle.
- o_busy  out  1  high in ADDR or RESP.

Behaviour:
- FSM states: IDLE, ADDR, RESP. Registers: state, grant index g, priority pointer p (master with priority on a tie).
- Reset (any cycle, including mid-transaction):
  - state=IDLE, p=0, grant cleared.
  - Next cycle: o_s_a_valid=0, o_s_d_ready=0, o_m_a_ready=0, o_m_d_valid=0, o_grant=0, o_busy=0.
  - Broadcast D fields pass the slave fields through and are don't-care; benches must check them only when qualified.
  - An in-flight slave response after reset is not forwarded.
- IDLE:
  - All readies and valids low.
  - If exactly one i_m_a_valid bit is set, grant that master.
  - If both are set, grant master p.
  - On grant, register g and go to ADDR next cycle. Arbitration takes one cycle.
- ADDR:
  - o_s_a_valid=1; o_s_a_* = fields of master g, muxed combinationally from the master's held A fields. TL-UL requires the master to hold fields stable while valid.
  - o_m_a_ready[g]=i_s_a_ready; the other bit is 0.
  - On i_s_a_ready=1, go to RESP. Otherwise stay; the grant is never revoked.
- RESP:
  - o_m_d_valid[g]=i_s_d_valid; o_s_d_ready=i_m_d_ready[g]; D fields pass through unchanged.
  - On i_s_d_valid & i_m_d_ready[g]: go to IDLE and set p=~g (other master gets priority).
- Minimum transaction: 3 cycles (grant, A handshake, D handshake), with a zero-wait slave.
- No pipelining: a new A is never forwarded before the current D handshake.
- i_s_d_valid in IDLE/ADDR: ignored, o_s_d_ready=0 (protocol violation by the slave; not forwarded).
- A losing master's a_valid may stay high indefinitely. It is served next because p alternates, so there is no starvation.
- o_grant = one-hot(g) in ADDR/RESP, else 0. o_busy = (state!=IDLE).
- a_source is passed through unchanged; no ID remapping.

Test Plan:
- Reset: assert i_reset 3 cycles with both masters valid -> o_s_a_valid=0, o_grant=0, o_m_a_ready=0 throughout; grant to m0 on the 1st cycle after release.
- Single master: m1 PutFull addr 0x0, data 0x000000A5, mask 0xF, slave always ready, D AccessAck in the next cycle -> o_s_a_* equal m1 fields, o_m_d_valid=2'b10, complete in 3 cycles, o_busy back to 0.
- Contention: both masters issue Get continuously for 4 transactions -> grant order m0, m1, m0, m1; o_m_d_valid never asserts on the wrong bit.
- Backpressure: slave holds a_ready=0 for 5 cycles, then m0 holds d_ready=0 for 3 cycles -> A fields stable, o_s_d_ready low until m0 ready, no re-arbitration meanwhile.
- Error/data passthrough: slave returns AccessAckData with data 0x3C and error=1 to m1 -> o_m_d_data=0x3C, o_m_d_error=1, o_m_d_source equals m1's a_source.
- Reset mid-RESP: assert i_reset while the D handshake is pending -> next cycle all valids and readies are 0, p=0, and the stale slave d_valid is not forwarded.
